// File: rtl/wbdnsz.sv
// Wishbone downsizer: replays each wide request as narrow beats and reassembles read data.
// Optional WBDNSZ_SKIPSEL_EN: skip narrow words whose byte selects are all zero.
module wbdnsz #(
  parameter int ADDRESS_WIDTH     = 28,
  parameter int WIDE_DW           = 64,
  parameter int SMALL_DW          = 32,
  parameter int OPT_LITTLE_ENDIAN = 0
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic                                         i_wcyc,
  input  logic                                         i_wstb,
  input  logic                                         i_wwe,
  input  logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]   i_waddr,
  input  logic [WIDE_DW-1:0]                           i_wdata,
  input  logic [WIDE_DW/8-1:0]                         i_wsel,
  output logic                                         o_wstall,
  output logic                                         o_wack,
  output logic                                         o_werr,
  output logic [WIDE_DW-1:0]                           o_wdata,
  output logic                                         o_scyc,
  output logic                                         o_sstb,
  output logic                                         o_swe,
  output logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0]  o_saddr,
  output logic [SMALL_DW-1:0]                          o_sdata,
  output logic [SMALL_DW/8-1:0]                        o_ssel,
  input  logic                                         i_sstall,
  input  logic                                         i_sack,
  input  logic                                         i_serr,
  input  logic [SMALL_DW-1:0]                          i_sdata
);

  localparam int R   = WIDE_DW / SMALL_DW;
  localparam int LGR = $clog2(R);
  localparam int WSB = WIDE_DW / 8;
  localparam int SSB = SMALL_DW / 8;
  localparam int WAW = ADDRESS_WIDTH - $clog2(WSB);
  localparam int CW  = LGR + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e               state_q;
  logic [WAW-1:0]       addr_q;
  logic [WIDE_DW-1:0]   data_q;
  logic [WSB-1:0]       sel_q;
  logic [R-1:0]         rem_q;       // words not yet issued
  logic [R-1:0]         ack_left_q;  // issued-or-pending words not yet acknowledged
  logic [LGR-1:0]       cur_k_q;
  logic [CW-1:0]        cnt_q;

  function automatic int pos(input logic [LGR-1:0] k);
    return (OPT_LITTLE_ENDIAN != 0) ? int'(k) : R - 1 - int'(k);
  endfunction

  function automatic logic [LGR-1:0] lowest(input logic [R-1:0] m);
    logic [LGR-1:0] r;
    r = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (m[i]) r = LGR'(i);
    end
    return r;
  endfunction

  function automatic logic [R-1:0] word_mask(input logic [WSB-1:0] s);
    logic [R-1:0] m;
    for (int k = 0; k < R; k++) m[k] = |s[pos(LGR'(k))*SSB +: SSB];
    return m;
  endfunction

  logic              acc;
  logic              beat;
  logic              sack_v;
  logic [LGR-1:0]    ack_lane;
  logic [R-1:0]      rem_nx;
  logic [R-1:0]      ack_nx;
  logic [CW-1:0]     cnt_nx;
  logic [LGR-1:0]    nxt_k;
  logic [R-1:0]      first_mask;
  logic [LGR-1:0]    first_k;

  always_comb begin
    acc      = i_wcyc && i_wstb && (state_q == StIdle);
    beat     = (state_q == StIssue) && !i_sstall;
    sack_v   = i_sack && o_scyc;
    ack_lane = lowest(ack_left_q);
    rem_nx   = beat ? (rem_q & ~(R'(1) << cur_k_q)) : rem_q;
    ack_nx   = sack_v ? (ack_left_q & ~(R'(1) << ack_lane)) : ack_left_q;
    cnt_nx   = cnt_q + CW'(beat) - CW'(sack_v);
    nxt_k    = lowest(rem_nx);
`ifdef WBDNSZ_SKIPSEL_EN
    first_mask = word_mask(i_wsel);
`else
    first_mask = {R{1'b1}};
`endif
    first_k  = lowest(first_mask);
  end

  assign o_wstall = (state_q != StIdle);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      rem_q      <= '0;
      ack_left_q <= '0;
      cur_k_q    <= '0;
      cnt_q      <= '0;
      o_wack     <= 1'b0;
      o_werr     <= 1'b0;
      o_wdata    <= '0;
      o_scyc     <= 1'b0;
      o_sstb     <= 1'b0;
      o_swe      <= 1'b0;
      o_saddr    <= '0;
      o_sdata    <= '0;
      o_ssel     <= '0;
    end else begin
      o_wack <= 1'b0;
      o_werr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (acc) begin
            addr_q  <= i_waddr;
            data_q  <= i_wdata;
            sel_q   <= i_wsel;
            cnt_q   <= '0;
            o_wdata <= '0;
            o_swe   <= i_wwe;
            if (i_wsel == '0) begin
              o_wack <= 1'b1;
            end else begin
              state_q    <= StIssue;
              rem_q      <= first_mask;
              ack_left_q <= first_mask;
              cur_k_q    <= first_k;
              o_scyc     <= 1'b1;
              o_sstb     <= 1'b1;
              o_saddr    <= {i_waddr, first_k};
              o_sdata    <= i_wdata[pos(first_k)*SMALL_DW +: SMALL_DW];
              o_ssel     <= i_wsel[pos(first_k)*SSB +: SSB];
            end
          end
        end
        default: begin
          if (!i_wcyc) begin
            // Initiator abandoned the cycle: drop silently, late acks are ignored in idle.
            state_q <= StIdle;
            o_scyc  <= 1'b0;
            o_sstb  <= 1'b0;
          end else if (i_serr) begin
            state_q <= StIdle;
            o_werr  <= 1'b1;
            o_scyc  <= 1'b0;
            o_sstb  <= 1'b0;
          end else begin
            if (sack_v) o_wdata[pos(ack_lane)*SMALL_DW +: SMALL_DW] <= i_sdata;
            rem_q      <= rem_nx;
            ack_left_q <= ack_nx;
            cnt_q      <= cnt_nx;
            if (beat) begin
              if (rem_nx != '0) begin
                cur_k_q <= nxt_k;
                o_saddr <= {addr_q, nxt_k};
                o_sdata <= data_q[pos(nxt_k)*SMALL_DW +: SMALL_DW];
                o_ssel  <= sel_q[pos(nxt_k)*SSB +: SSB];
              end else begin
                state_q <= StWait;
                o_sstb  <= 1'b0;
              end
            end
            if (rem_nx == '0 && cnt_nx == '0) begin
              state_q <= StIdle;
              o_wack  <= 1'b1;
              o_scyc  <= 1'b0;
              o_sstb  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbdnsz.sv
// Directed bench for wbdnsz (64b -> 32b, big-endian) with an in-bench narrow responder.
module tb_wbdnsz;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wcyc = 1'b0, i_wstb = 1'b0, i_wwe = 1'b0;
  logic [24:0] i_waddr = '0;
  logic [63:0] i_wdata = '0;
  logic [7:0]  i_wsel = '0;
  logic        o_wstall, o_wack, o_werr;
  logic [63:0] o_wdata;
  logic        o_scyc, o_sstb, o_swe;
  logic [25:0] o_saddr;
  logic [31:0] o_sdata;
  logic [3:0]  o_ssel;
  logic        i_sstall = 1'b0, i_sack = 1'b0, i_serr = 1'b0;
  logic [31:0] i_sdata = '0;

  always #5 i_clk = ~i_clk;

  wbdnsz dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wcyc(i_wcyc), .i_wstb(i_wstb), .i_wwe(i_wwe),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wsel(i_wsel),
    .o_wstall(o_wstall), .o_wack(o_wack), .o_werr(o_werr), .o_wdata(o_wdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sstall(i_sstall), .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata)
  );

  int checks = 0;
  int failures = 0;

  logic [25:0] beat_addr[8];
  logic [31:0] beat_data[8];
  logic [3:0]  beat_sel[8];
  logic        beat_we[8];
  int          nbeats, nack, nerr, cyc, ev_cyc, stall_left;
  bit          err_mode;
  logic [63:0] ack_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [25:0] a);
    if (a == 26'h21) return 32'hCAFEF00D;
    return 32'hA5000000 | 32'(a);
  endfunction

  // One clock: responder acks each accepted beat on the next cycle.
  task automatic tick();
    logic        took;
    logic [25:0] a;
    took = o_scyc && o_sstb && !i_sstall;
    a    = o_saddr;
    if (took && nbeats < 8) begin
      beat_addr[nbeats] = o_saddr;
      beat_data[nbeats] = o_sdata;
      beat_sel[nbeats]  = o_ssel;
      beat_we[nbeats]   = o_swe;
      nbeats++;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    i_sack  = took;
    i_serr  = took && err_mode;
    if (took) err_mode = 1'b0;
    i_sdata = took ? rd_val(a) : '0;
    if (stall_left > 0) begin
      i_sstall = 1'b1;
      stall_left--;
    end else begin
      i_sstall = 1'b0;
    end
    if (o_wack) begin
      nack++;
      ack_data = o_wdata;
      if (ev_cyc < 0) ev_cyc = cyc;
    end
    if (o_werr) begin
      nerr++;
      if (ev_cyc < 0) ev_cyc = cyc;
    end
  endtask

  task automatic clear();
    nbeats = 0; nack = 0; nerr = 0; cyc = 0; ev_cyc = -1;
  endtask

  task automatic start_req(input logic we, input logic [24:0] a, input logic [63:0] d,
                           input logic [7:0] s);
    clear();
    i_wcyc = 1'b1; i_wstb = 1'b1; i_wwe = we;
    i_waddr = a; i_wdata = d; i_wsel = s;
    tick();
    i_wstb = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [24:0] a, input logic [63:0] d,
                        input logic [7:0] s);
    start_req(we, a, d, s);
    for (int i = 0; i < 30 && ev_cyc < 0; i++) tick();
    check_eq("req_done", 64'(ev_cyc >= 0), 64'd1);
    i_wcyc = 1'b0;
  endtask

  initial begin
    clear();
    stall_left = 0;
    err_mode   = 1'b0;
    ack_data   = '0;
    repeat (2) tick();
    check_eq("rst_outs", {59'd0, o_wack, o_werr, o_scyc, o_sstb, o_wstall}, 64'd0);
    check_eq("rst_wdata", o_wdata, 64'd0);
    i_reset = 1'b0;
    tick();

    // Full-width write
    do_req(1'b1, 25'h10, 64'h1122334455667788, 8'hFF);
    check_eq("fw_nbeats", 64'(nbeats), 64'd2);
    check_eq("fw_b0", {beat_we[0], beat_sel[0], beat_addr[0], beat_data[0]},
             {1'b1, 4'hF, 26'h20, 32'h11223344});
    check_eq("fw_b1", {beat_we[1], beat_sel[1], beat_addr[1], beat_data[1]},
             {1'b1, 4'hF, 26'h21, 32'h55667788});
    check_eq("fw_ack_cyc", 64'(ev_cyc), 64'd4);
    check_eq("fw_counts", {32'(nack), 32'(nerr)}, {32'd1, 32'd0});
    tick();

    // Partial read, lower word only
    do_req(1'b0, 25'h10, 64'h0, 8'h0F);
`ifdef WBDNSZ_SKIPSEL_EN
    check_eq("pr_nbeats", 64'(nbeats), 64'd1);
    check_eq("pr_b0", {beat_sel[0], beat_addr[0]}, {4'hF, 26'h21});
    check_eq("pr_data", ack_data, 64'h00000000CAFEF00D);
    check_eq("pr_ack_cyc", 64'(ev_cyc), 64'd3);
`else
    check_eq("pr_nbeats", 64'(nbeats), 64'd2);
    check_eq("pr_b0", {beat_we[0], beat_sel[0], beat_addr[0]}, {1'b0, 4'h0, 26'h20});
    check_eq("pr_b1", {beat_sel[1], beat_addr[1]}, {4'hF, 26'h21});
    check_eq("pr_data", ack_data, 64'hA5000020CAFEF00D);
    check_eq("pr_ack_cyc", 64'(ev_cyc), 64'd4);
`endif
    tick();

    // Full read: lane ordering of reassembled data
    do_req(1'b0, 25'h33, 64'h0, 8'hFF);
    check_eq("rd_addrs", {beat_addr[0], beat_addr[1]}, {26'h66, 26'h67});
    check_eq("rd_data", ack_data, 64'hA5000066A5000067);
    check_eq("rd_ack_cyc", 64'(ev_cyc), 64'd4);
    tick();

    // Stall on first beat for 3 cycles
    stall_left = 3;
    start_req(1'b1, 25'h10, 64'hDEADBEEF01234567, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("st_hold", {o_sstb, o_saddr, o_sdata}, {1'b1, 26'h20, 32'hDEADBEEF});
    end
    for (int i = 0; i < 30 && ev_cyc < 0; i++) tick();
    check_eq("st_done", 64'(ev_cyc), 64'd7);
    check_eq("st_nbeats", 64'(nbeats), 64'd2);
    check_eq("st_b1", {beat_addr[1], beat_data[1]}, {26'h21, 32'h01234567});
    i_wcyc = 1'b0;
    tick();

    // Error on first ack of a 2-beat read
    err_mode = 1'b1;
    do_req(1'b0, 25'h10, 64'h0, 8'hFF);
    check_eq("er_cyc_scyc", {63'(ev_cyc), o_scyc}, {63'd3, 1'b0});
    repeat (3) tick();
    check_eq("er_counts", {32'(nack), 32'(nerr)}, {32'd0, 32'd1});

    // Abort in WAIT coinciding with the final ack
    start_req(1'b0, 25'h10, 64'h0, 8'hFF);
    tick();
    tick();
    check_eq("ab_wait", {o_scyc, o_sstb, o_wstall}, {1'b1, 1'b0, 1'b1});
    i_wcyc = 1'b0;
    tick();
    check_eq("ab_idle", {o_scyc, o_sstb, o_wstall, o_wack, o_werr}, 5'd0);
    repeat (2) tick();
    check_eq("ab_counts", {32'(nack), 32'(nerr)}, 64'd0);

    // Zero-select shortcut
    do_req(1'b1, 25'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    check_eq("zs_ack_cyc", 64'(ev_cyc), 64'd1);
    check_eq("zs_data", ack_data, 64'd0);
    repeat (2) tick();
    check_eq("zs_beats_acks", {32'(nbeats), 32'(nack)}, {32'd0, 32'd1});

    // Asynchronous reset mid-ISSUE
    stall_left = 5;
    start_req(1'b1, 25'h10, 64'h1122334455667788, 8'hFF);
    check_eq("ar_issue", {o_scyc, o_sstb}, 2'b11);
    #2;
    i_reset = 1'b1;
    #1;
    check_eq("ar_outs", {o_wack, o_werr, o_scyc, o_sstb, o_swe, o_wstall, o_ssel, o_saddr,
                         o_sdata}, 68'd0);
    stall_left = 0;
    i_sstall = 1'b0;
    i_wcyc = 1'b0;
    #1;
    i_reset = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
